// File: rtl/carry_tick_timer.sv
// rtl/carry_tick_timer.sv - programmable tick-count timeout with expiry pulse, sticky done and overrun
module carry_tick_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             start,
    input  logic             stop,
    input  logic             auto_reload,
    input  logic [WIDTH-1:0] period,
    input  logic             ack,
    output logic [WIDTH-1:0] remaining,
    output logic             busy,
    output logic             expired,
    output logic             done,
    output logic             overrun
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ARMED   = 2'd1;
    localparam logic [1:0] EXPIRED = 2'd2;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [1:0]       state;
    logic [1:0]       state_n;
    logic [WIDTH-1:0] period_q;
    logic [WIDTH-1:0] period_q_n;
    logic [WIDTH-1:0] remaining_n;
    logic             start_ok;
    logic             expiry;

    assign start_ok = start && (period != '0);

    // stop pre-empts start, and an accepted start discards any same-cycle tick
    always_comb begin
        state_n     = state;
        remaining_n = remaining;
        period_q_n  = period_q;
        expiry      = 1'b0;
        if (stop) begin
            state_n     = IDLE;
            remaining_n = '0;
        end else if (start_ok) begin
            state_n     = ARMED;
            remaining_n = period;
            period_q_n  = period;
        end else begin
            case (state)
                ARMED: begin
                    if (tick) begin
                        if (remaining == ONE) begin
                            expiry = 1'b1;
                            if (auto_reload) begin
                                remaining_n = period_q;
                            end else begin
                                remaining_n = '0;
                                state_n     = EXPIRED;
                            end
                        end else begin
                            remaining_n = remaining - ONE;
                        end
                    end
                end
                EXPIRED: begin
                    if (ack) begin
                        state_n = IDLE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // a set from expiry beats a same-cycle ack on done; overrun needs done to survive the ack
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            remaining <= '0;
            period_q  <= '0;
            busy      <= 1'b0;
            expired   <= 1'b0;
            done      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_n;
            remaining <= remaining_n;
            period_q  <= period_q_n;
            busy      <= (state_n == ARMED);
            expired   <= expiry;
            done      <= expiry | (done & ~ack);
            overrun   <= ~ack & (overrun | (expiry & done));
        end
    end

endmodule

// File: tb/tb_carry_tick_timer.sv
// tb/tb_carry_tick_timer.sv - scoreboard bench for carry_tick_timer with directed vectors
module tb_carry_tick_timer;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             tick;
    logic             start;
    logic             stop;
    logic             auto_reload;
    logic [WIDTH-1:0] period;
    logic             ack;
    logic [WIDTH-1:0] remaining;
    logic             busy;
    logic             expired;
    logic             done;
    logic             overrun;

    int tests_run = 0;
    int tests_failed = 0;
    int row = 0;

    // expected response: {remaining, busy, expired, done, overrun} tagged with row number
    typedef struct {
        int          idx;
        logic [11:0] resp;
    } exp_t;

    exp_t sb[$];

    carry_tick_timer #(.WIDTH(WIDTH)) dut (
        .clk(clk),
        .reset(reset),
        .tick(tick),
        .start(start),
        .stop(stop),
        .auto_reload(auto_reload),
        .period(period),
        .ack(ack),
        .remaining(remaining),
        .busy(busy),
        .expired(expired),
        .done(done),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic v(input logic r, input logic t, input logic s, input logic sp,
                     input logic ar, input logic [WIDTH-1:0] p, input logic a,
                     input logic [WIDTH-1:0] e_rem, input logic e_busy,
                     input logic e_exp, input logic e_done, input logic e_ovr);
        exp_t e;
        @(negedge clk);
        reset       = r;
        tick        = t;
        start       = s;
        stop        = sp;
        auto_reload = ar;
        period      = p;
        ack         = a;
        e.idx  = row;
        e.resp = {e_rem, e_busy, e_exp, e_done, e_ovr};
        sb.push_back(e);
        row++;
    endtask

    // monitor: outputs are valid every cycle, sampled just after the edge
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            exp_t e;
            logic [11:0] act;
            e   = sb.pop_front();
            act = {remaining, busy, expired, done, overrun};
            tests_run++;
            if (act !== e.resp) begin
                tests_failed++;
                $display("FAIL row%0d rem/busy/exp/done/ovr got %0d/%b/%b/%b/%b want %0d/%b/%b/%b/%b",
                         e.idx, act[11:4], act[3], act[2], act[1], act[0],
                         e.resp[11:4], e.resp[3], e.resp[2], e.resp[1], e.resp[0]);
            end
        end
    end

    initial begin
        reset = 1'b1; tick = 1'b0; start = 1'b0; stop = 1'b0;
        auto_reload = 1'b0; period = '0; ack = 1'b0;

        //  r  t  s  sp ar per ack   rem busy exp done ovr
        v(1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
        // one-shot period 5, tick every third cycle
        v(0, 0, 1, 0, 0, 5, 0,   5, 1, 0, 0, 0);
        v(0, 0, 0, 0, 0, 0, 0,   5, 1, 0, 0, 0);
        v(0, 0, 0, 0, 0, 0, 0,   5, 1, 0, 0, 0);
        v(0, 1, 0, 0, 0, 0, 0,   4, 1, 0, 0, 0);
        v(0, 0, 0, 0, 0, 0, 0,   4, 1, 0, 0, 0);
        v(0, 0, 0, 0, 0, 0, 0,   4, 1, 0, 0, 0);
        v(0, 1, 0, 0, 0, 0, 0,   3, 1, 0, 0, 0);
        v(0, 0, 0, 0, 0, 0, 0,   3, 1, 0, 0, 0);
        v(0, 0, 0, 0, 0, 0, 0,   3, 1, 0, 0, 0);
        v(0, 1, 0, 0, 0, 0, 0,   2, 1, 0, 0, 0);
        v(0, 0, 0, 0, 0, 0, 0,   2, 1, 0, 0, 0);
        v(0, 0, 0, 0, 0, 0, 0,   2, 1, 0, 0, 0);
        v(0, 1, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0);
        v(0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0);
        v(0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0);
        v(0, 1, 0, 0, 0, 0, 0,   0, 0, 1, 1, 0);
        v(0, 1, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0);
        v(0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0);
        // idle: tick ignored, zero-period start ignored
        v(0, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
        v(0, 1, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0);
        // auto-reload period 2, tick every cycle
        v(0, 0, 1, 0, 1, 2, 0,   2, 1, 0, 0, 0);
        v(0, 1, 0, 0, 1, 0, 0,   1, 1, 0, 0, 0);
        v(0, 1, 0, 0, 1, 0, 0,   2, 1, 1, 1, 0);
        v(0, 1, 0, 0, 1, 0, 0,   1, 1, 0, 1, 0);
        v(0, 1, 0, 0, 1, 0, 0,   2, 1, 1, 1, 1);
        v(0, 0, 0, 0, 1, 0, 1,   2, 1, 0, 0, 0);
        v(0, 0, 0, 1, 1, 0, 0,   0, 0, 0, 0, 0);
        // restart discards tick, then stop with tick
        v(0, 0, 1, 0, 0, 5, 0,   5, 1, 0, 0, 0);
        v(0, 1, 0, 0, 0, 0, 0,   4, 1, 0, 0, 0);
        v(0, 1, 0, 0, 0, 0, 0,   3, 1, 0, 0, 0);
        v(0, 1, 1, 0, 0, 10, 0, 10, 1, 0, 0, 0);
        v(0, 1, 0, 1, 0, 0, 0,   0, 0, 0, 0, 0);
        v(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
        // period 1 auto-reload: expiry every tick, expiry with ack
        v(0, 0, 1, 0, 1, 1, 0,   1, 1, 0, 0, 0);
        v(0, 1, 0, 0, 1, 0, 0,   1, 1, 1, 1, 0);
        v(0, 1, 0, 0, 1, 0, 1,   1, 1, 1, 1, 0);
        v(0, 1, 0, 0, 1, 0, 0,   1, 1, 1, 1, 1);
        v(0, 0, 0, 0, 1, 0, 1,   1, 1, 0, 0, 0);
        // build done+overrun, zero-period restart lets tick through, then reset
        v(0, 1, 0, 0, 1, 0, 0,   1, 1, 1, 1, 0);
        v(0, 1, 0, 0, 1, 0, 0,   1, 1, 1, 1, 1);
        v(0, 0, 1, 0, 1, 5, 0,   5, 1, 0, 1, 1);
        v(0, 1, 1, 0, 1, 0, 0,   4, 1, 0, 1, 1);
        v(1, 1, 0, 0, 1, 0, 0,   0, 0, 0, 0, 0);
        v(0, 1, 0, 0, 1, 0, 0,   0, 0, 0, 0, 0);
        v(0, 1, 0, 0, 1, 0, 0,   0, 0, 0, 0, 0);

        repeat (3) @(posedge clk);
        #2;
        tests_run++;
        if (sb.size() != 0) begin
            tests_failed++;
            $display("FAIL drain queue left %0d want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/carry_tick_timer.md
Name: carry_tick_timer

Overview:
- Programmable timeout stage directly downstream of the free-running counter; consumes its one-cycle carry pulse as a timebase tick.
- Counts a loaded number of ticks, then flags expiry as a one-cycle pulse plus a sticky flag held until acknowledged.
- Runs one-shot or auto-reload; auto-reload mode detects an expiry that arrives while the previous one is still unacknowledged.
- Provides the alarm/interrupt source for the control logic above the counter chain.

Parameters:
WIDTH, 8, width of period and remaining-tick count

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
tick  input  1  timebase pulse (upstream counter carry); one tick per cycle when high
start  input  1  load period and arm timer
stop  input  1  abort timer and return to IDLE
auto_reload  input  1  1 = reload period_q on expiry and stay armed; sampled on the expiry cycle
period  input  WIDTH  tick count to expiry; sampled only when start is accepted
ack  input  1  clears done and overrun
remaining  output  WIDTH  ticks left before expiry (registered)
busy  output  1  high in ARMED
expired  output  1  one-cycle expiry pulse
done  output  1  sticky expiry flag
overrun  output  1  sticky: expiry occurred while done was still set

Behaviour:
- One clock, synchronous active-high reset. All outputs registered.
- Reset values: state=IDLE, remaining=0, period_q=0, busy=0, expired=0, done=0, overrun=0.
- Priority within a cycle: reset > stop > start > tick. ack is evaluated independently of this order.
- States: IDLE, ARMED, EXPIRED. busy=1 exactly when state=ARMED.
- IDLE:
  - start with period!=0 -> period_q<=period, remaining<=period, go to ARMED.
  - start with period==0 -> ignored, stay IDLE.
  - tick ignored.
- ARMED, tick=1 and remaining>1 -> remaining<=remaining-1.
- ARMED, tick=1 and remaining==1 (expiry):
  - expired<=1 for exactly one cycle; done<=1.
  - If done was already 1 and is not being cleared by ack this cycle -> overrun<=1.
  - auto_reload=1 -> remaining<=period_q, stay ARMED.
  - auto_reload=0 -> remaining<=0, go to EXPIRED.
- ARMED, tick=0 -> hold remaining.
- start in ARMED or EXPIRED (restart):
  - period!=0 -> reload period_q and remaining from period, go to ARMED. A tick in the same cycle is discarded and no expiry occurs.
  - period==0 -> ignored; state unchanged and the same-cycle tick is processed normally.
- EXPIRED: remaining=0; ticks ignored. start re-arms. stop or ack returns to IDLE.
- stop (any state): remaining<=0, go to IDLE. done and overrun are unchanged. Suppresses a same-cycle expiry.
- ack: clears done and overrun next cycle. If expiry and ack occur in the same cycle, set wins (done=1) and overrun is not set.
- Latency: expired/done are high in the cycle after the clock edge that samples the final tick. The remaining update is visible one cycle after the tick.
- period_q=1 with auto_reload and tick every cycle -> expired high every cycle; overrun sets on the second expiry unless ack is held.
- Width: period up to 2^WIDTH-1. Decrement never wraps, because the remaining==1 path pre-empts it.

Test Plan:
- Reset then start, period=5, auto_reload=0, tick every 3rd cycle -> remaining 5,4,3,2,1,0; expired one cycle after 5th tick; done=1; state EXPIRED, busy=0; ack -> done=0, IDLE.
- start, period=0 in IDLE -> no state change, busy=0, remaining=0.
- auto_reload=1, period=2, tick every cycle, no ack -> expired every 2 cycles; overrun=1 after 2nd expiry; remaining cycles 2,1,2,1; ack clears done and overrun.
- ARMED with remaining=3; assert start with period=10 and tick in the same cycle -> remaining=10, tick discarded; then stop with tick -> IDLE, remaining=0, no expired.
- Expiry cycle coincides with ack while done=1 -> done stays 1, overrun stays 0.
- Assert reset mid-count (remaining=4, done=1, overrun=1) -> next cycle all outputs 0, IDLE; ticks ignored until start.
